highlight_frame_expander: RTL and testbench

// - Output-side counterpart of the cropped input path: drains the 8-bit highlight FIFO
//   (REDUCED_WIDTH x REDUCED_HEIGHT region) and rebuilds a full WIDTH x HEIGHT raster.
// - Emits one 24-bit pixel per accepted cycle into a downstream output FIFO.
// - Region pixels carry the highlight byte; all other pixels carry PAD_PIXEL (green).
// - Sits after hough_top's highlight FIFO and feeds the frame writer / display path.

---
 rtl/highlight_frame_expander.sv | 126 ++++++++++++
 tb/tb_highlight_frame_expander.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/highlight_frame_expander.sv
// highlight_frame_expander
// Drains the cropped 8-bit highlight FIFO and rebuilds a full WIDTH x HEIGHT
// raster of 24-bit {B,G,R} pixels. Pixels inside the region carry the
// highlight byte in R. All other pixels carry PAD_PIXEL.
//
// Handshake: a pixel moves when the downstream FIFO is not full and, for
// region pixels, the FWFT highlight FIFO is not empty. In that same cycle
// out_wr_en pulses, and highlight_rd_en pulses too for region pixels only.
// Both enables are combinational, so there is zero latency and up to one
// pixel per cycle.
module highlight_frame_expander #(
    parameter int          WIDTH          = 1280,
    parameter int          HEIGHT         = 720,
    parameter int          REDUCED_WIDTH  = 568,
    parameter int          REDUCED_HEIGHT = 320,
    parameter int          X_OFFSET       = 0,
    parameter int          Y_OFFSET       = 0,
    parameter logic [23:0] PAD_PIXEL      = 24'h00FF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  highlight_dout,
    input  logic        highlight_empty,
    output logic        highlight_rd_en,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [23:0] out_din,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fsm_state
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    // A region that does not fit inside the frame can never be drained correctly.
    if (X_OFFSET < 0 || Y_OFFSET < 0 ||
        X_OFFSET + REDUCED_WIDTH  > WIDTH ||
        Y_OFFSET + REDUCED_HEIGHT > HEIGHT) begin : g_region_check
        $error("highlight_frame_expander: highlight region lies outside the frame");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           in_region;
    logic           last_pixel;
    logic           push;

    assign fsm_state = state;

    // Signed 32-bit comparisons keep a zero offset from becoming an always-true unsigned test.
    assign in_region = (int'(x) >= X_OFFSET) && (int'(x) < X_OFFSET + REDUCED_WIDTH) &&
                       (int'(y) >= Y_OFFSET) && (int'(y) < Y_OFFSET + REDUCED_HEIGHT);

    assign last_pixel = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));

    // A pixel is pushed in RUN when downstream has room and region pixels have data.
    assign push = (state == S_RUN) && !out_full && (!in_region || !highlight_empty);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start only matters in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (push && last_pixel) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode. out_din is zero whenever nothing is pushed.
    always_comb begin
        highlight_rd_en = 1'b0;
        out_wr_en       = 1'b0;
        out_din         = 24'h000000;
        busy            = (state == S_RUN);
        done            = (state == S_DONE);
        if (push) begin
            out_wr_en = 1'b1;
            if (in_region) begin
                highlight_rd_en = 1'b1;
                out_din         = {16'h0000, highlight_dout};
            end else begin
                out_din = PAD_PIXEL;
            end
        end
    end

    // Raster position. It advances on each push and wraps to (0,0) after the last pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (push) begin
            if (x == XW'(WIDTH - 1)) begin
                x <= '0;
                if (y == YW'(HEIGHT - 1)) begin
                    y <= '0;
                end else begin
                    y <= y + YW'(1);
                end
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: tb/tb_highlight_frame_expander.sv
// tb_highlight_frame_expander
// Small-frame bench (8x4 frame, 3x2 region at (2,1)) built around a queue-based
// FWFT highlight FIFO model and a raster reference model feeding an expected queue.
module tb_highlight_frame_expander;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int RW = 3;
  localparam int RH = 2;
  localparam int XO = 2;
  localparam int YO = 1;
  localparam logic [23:0] PAD = 24'h00FF00;
  localparam int NPIX = W * H;
  localparam int NPOP = RW * RH;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  highlight_dout;
  logic        highlight_empty;
  logic        highlight_rd_en;
  logic        out_full;
  logic        out_wr_en;
  logic [23:0] out_din;
  logic        busy;
  logic        done;
  logic [1:0]  fsm_state;

  highlight_frame_expander #(
    .WIDTH(W), .HEIGHT(H), .REDUCED_WIDTH(RW), .REDUCED_HEIGHT(RH),
    .X_OFFSET(XO), .Y_OFFSET(YO), .PAD_PIXEL(PAD)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .highlight_dout(highlight_dout), .highlight_empty(highlight_empty),
    .highlight_rd_en(highlight_rd_en), .out_full(out_full),
    .out_wr_en(out_wr_en), .out_din(out_din),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- shared state ----------------
  logic [7:0]  hl_q[$];
  logic [23:0] exp_q[$];
  logic        exp_rd_q[$];
  logic [7:0]  frame_bytes[NPOP];
  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int full_mode = 0;
  bit rand_stall_en = 0;
  bit rand_stall = 0;
  bit pend_pop = 0;
  bit prev_last = 0;

  task automatic check_val(input string name, input logic [23:0] act, input logic [23:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic refresh_fifo();
    highlight_empty = rand_stall || (hl_q.size() == 0);
    highlight_dout  = (hl_q.size() != 0) ? hl_q[0] : 8'h00;
  endtask

  // Reference model: walk the raster in row-major order and pair each region
  // pixel with the next highlight byte.
  task automatic build_expected();
    int k;
    k = 0;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        if (xx >= XO && xx < XO + RW && yy >= YO && yy < YO + RH) begin
          exp_q.push_back({16'h0000, frame_bytes[k]});
          exp_rd_q.push_back(1'b1);
          k++;
        end else begin
          exp_q.push_back(PAD);
          exp_rd_q.push_back(1'b0);
        end
      end
    end
  endtask

  task automatic set_bytes(input bit rnd);
    for (int i = 0; i < NPOP; i++)
      frame_bytes[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
  endtask

  task automatic load_bytes(input int extra);
    for (int i = 0; i < NPOP; i++) hl_q.push_back(frame_bytes[i]);
    for (int i = 0; i < extra; i++) hl_q.push_back(8'($urandom_range(0, 255)));
    refresh_fifo();
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor_cycle();
    logic [23:0] e;
    logic        er;
    pend_pop = highlight_rd_en;
    if (reset) begin
      prev_last = 1'b0;
      return;
    end
    check_val("done_timing", 24'(done), 24'(prev_last));
    prev_last = 1'b0;
    if (done) done_cnt++;
    check_val("push_while_full", 24'(out_wr_en && out_full), 24'h0);
    check_val("pop_while_empty", 24'(highlight_rd_en && highlight_empty), 24'h0);
    if (out_wr_en) begin
      push_cnt++;
      if (highlight_rd_en) pop_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push got %h expected no push at %0t", out_din, $time);
      end else begin
        e  = exp_q.pop_front();
        er = exp_rd_q.pop_front();
        check_val("pixel", out_din, e);
        check_val("rd_en_with_push", 24'(highlight_rd_en), 24'(er));
        if (exp_q.size() == 0) prev_last = 1'b1;
      end
    end else begin
      check_val("rd_en_no_push", 24'(highlight_rd_en), 24'h0);
      check_val("din_no_push", out_din, 24'h0);
    end
  endtask

  // ---------------- driver: FIFO model and downstream back-pressure ----------------
  initial begin
    out_full = 1'b0;
    highlight_dout = 8'h00;
    highlight_empty = 1'b1;
    forever begin
      @(negedge clock);
      monitor_cycle();
      @(posedge clock);
      #1;
      if (pend_pop && hl_q.size() != 0) void'(hl_q.pop_front());
      case (full_mode)
        0: out_full = 1'b0;
        1: out_full = ~out_full;
        default: out_full = ($urandom_range(0, 3) == 0);
      endcase
      rand_stall = rand_stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
      refresh_fifo();
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit inj_done);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < bound) begin
      step();
      n++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_timeout got no done expected done within %0d cycles", bound);
    end
    if (seen && inj_done) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    repeat (4) step();
  endtask

  task automatic frame_checks(input int pb, input int qb, input int db);
    check_val("frame_pushes", 24'(push_cnt - pb), 24'(NPIX));
    check_val("frame_pops", 24'(pop_cnt - qb), 24'(NPOP));
    check_val("frame_done_pulses", 24'(done_cnt - db), 24'd1);
    check_val("exp_left", 24'(exp_q.size()), 24'd0);
    check_val("busy_after", 24'(busy), 24'd0);
  endtask

  task automatic run_frame(input int fmode, input bit rstall, input bit inj_busy, input bit inj_done);
    int pb, qb, db;
    pb = push_cnt;
    qb = pop_cnt;
    db = done_cnt;
    full_mode = fmode;
    rand_stall_en = rstall;
    build_expected();
    pulse_start();
    if (inj_busy) begin
      repeat (7) step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_done(2000, inj_done);
    full_mode = 0;
    rand_stall_en = 0;
    repeat (2) step();
    frame_checks(pb, qb, db);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pb, qb, db, n;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) step();
    check_val("rst_busy", 24'(busy), 24'd0);
    check_val("rst_done", 24'(done), 24'd0);
    check_val("rst_wr_en", 24'(out_wr_en), 24'd0);
    check_val("rst_rd_en", 24'(highlight_rd_en), 24'd0);
    check_val("rst_din", out_din, 24'd0);
    check_val("rst_state", 24'(fsm_state), 24'd0);
    reset = 1'b0;
    step();

    // Full frame without stalls, bytes 1..6.
    set_bytes(0);
    load_bytes(0);
    run_frame(0, 0, 0, 0);

    // Highlight FIFO empty when the raster reaches (2,1).
    set_bytes(0);
    build_expected();
    pb = push_cnt; qb = pop_cnt; db = done_cnt;
    pulse_start();
    n = 0;
    while (push_cnt - pb < 10 && n < 200) begin step(); n++; end
    repeat (5) step();
    check_val("stall_pushes", 24'(push_cnt - pb), 24'd10);
    check_val("stall_pops", 24'(pop_cnt - qb), 24'd0);
    check_val("stall_busy", 24'(busy), 24'd1);
    load_bytes(0);
    wait_done(2000, 0);
    frame_checks(pb, qb, db);

    // Downstream full every other cycle.
    set_bytes(0);
    load_bytes(0);
    run_frame(1, 0, 0, 0);

    // Reset after 15 pushes, then a clean restart from (0,0).
    set_bytes(0);
    load_bytes(0);
    build_expected();
    pb = push_cnt;
    pulse_start();
    n = 0;
    while (push_cnt - pb < 15 && n < 200) begin step(); n++; end
    reset = 1'b1;
    exp_q.delete();
    exp_rd_q.delete();
    step();
    check_val("midrst_busy", 24'(busy), 24'd0);
    check_val("midrst_wr_en", 24'(out_wr_en), 24'd0);
    check_val("midrst_rd_en", 24'(highlight_rd_en), 24'd0);
    reset = 1'b0;
    hl_q.delete();
    refresh_fifo();
    step();
    set_bytes(0);
    load_bytes(0);
    run_frame(0, 0, 0, 0);

    // start while busy and during DONE is ignored.
    set_bytes(1);
    load_bytes(0);
    run_frame(0, 0, 1, 1);

    // Surplus highlight data stays in the FIFO.
    set_bytes(1);
    load_bytes(2);
    run_frame(0, 0, 0, 0);
    check_val("surplus_left", 24'(hl_q.size()), 24'd2);
    check_val("surplus_empty", 24'(highlight_empty), 24'd0);
    hl_q.delete();
    refresh_fifo();

    // Randomized back-pressure and highlight stalls.
    for (int f = 0; f < 3; f++) begin
      set_bytes(1);
      load_bytes(0);
      run_frame(2, 1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
